// File: rtl/pwm_capture.sv
// PWM / fan-tach receiver: measures the high time and full period of pwm_i in
// clk_en_i ticks (rising edge to rising edge), with a saturation timeout.
module pwm_capture #(
    parameter int COUNTER_BITWIDTH = 5,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        clk_en_i,
    input  logic                        pwm_i,
    output logic [COUNTER_BITWIDTH+1:0] highCount_o,
    output logic [COUNTER_BITWIDTH+1:0] periodCount_o,
    output logic                        valid_o,
    output logic                        timeout_o
);
    localparam int CW = COUNTER_BITWIDTH + 2;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_vld_q;
    logic                   pwm_s, tick, rise, fall;

    state_e                 state_q, state_d;
    logic [CW-1:0]          period_q, period_d, high_q, high_d;
    logic [CW-1:0]          high_out_q, high_out_d, period_out_q, period_out_d;
    logic                   prev_q, prev_d, valid_q, valid_d, timeout_q, timeout_d;

    // Ticks are ignored until the chain has refilled after reset, so a line
    // that is already high at reset never appears as a 0->1 transition.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q     <= '0;
            sync_vld_q <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pwm_i};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign tick  = clk_en_i & sync_vld_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~prev_q;
    assign fall  = ~pwm_s & prev_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            period_q     <= '0;
            high_q       <= '0;
            prev_q       <= 1'b1;
            high_out_q   <= '0;
            period_out_q <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q      <= state_d;
            period_q     <= period_d;
            high_q       <= high_d;
            prev_q       <= prev_d;
            high_out_q   <= high_out_d;
            period_out_q <= period_out_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d      = state_q;
        period_d     = period_q;
        high_d       = high_q;
        prev_d       = prev_q;
        high_out_d   = high_out_q;
        period_out_d = period_out_q;
        valid_d      = 1'b0;
        timeout_d    = timeout_q;

        if (tick) begin
            prev_d = pwm_s;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        period_d = CNT_ONE;
                        high_d   = CNT_ONE;
                        state_d  = HIGH;
                    end
                end
                HIGH, LOW: begin
                    if (rise) begin
                        // A rise wins over saturation on the same tick.
                        high_out_d   = high_q;
                        period_out_d = period_q;
                        valid_d      = 1'b1;
                        timeout_d    = 1'b0;
                        period_d     = CNT_ONE;
                        high_d       = CNT_ONE;
                        state_d      = HIGH;
                    end else if (period_q == CNT_MAX) begin
                        high_out_d   = pwm_s ? CNT_MAX : '0;
                        period_out_d = CNT_MAX;
                        timeout_d    = 1'b1;
                        period_d     = '0;
                        high_d       = '0;
                        state_d      = IDLE;
                    end else begin
                        period_d = period_q + CNT_ONE;
                        if (state_q == HIGH) begin
                            if (fall) state_d = LOW;
                            else      high_d  = high_q + CNT_ONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign highCount_o   = high_out_q;
    assign periodCount_o = period_out_q;
    assign valid_o       = valid_q;
    assign timeout_o     = timeout_q;

endmodule
